// File: rtl/fir_sched_pkg.sv
// Shared types, default sizing and width helper for the FIR channel scheduler.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // clog2 that never returns zero, so a 1-channel or 2-channel select still has a bit
  function automatic int unsigned width_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int unsigned DEF_NUM_CH    = 2;
  localparam int unsigned DEF_BURST     = 16;
  localparam int unsigned DEF_DECIM     = 8;
  localparam int unsigned OUT_PER_BURST = DEF_BURST / DEF_DECIM;
  localparam int unsigned CH_W          = width_min1(DEF_NUM_CH);

endpackage

// File: rtl/fir_ch_scheduler_rr_pick.sv
// Combinational round-robin finder: first asserted request at or after start, wrapping.
module rr_pick
  import fir_sched_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned W = width_min1(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         hit_o,
  output logic [W-1:0] idx_o
);

  int unsigned j;

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    j     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (32'(start_i) + i) % N;
      if (!hit_o && req_i[W'(j)]) begin
        hit_o = 1'b1;
        idx_o = W'(j);
      end
    end
  end

endmodule

// File: rtl/fir_ch_scheduler.sv
// Round-robin time-sharing of one multi-context FIR engine between NUM_CH FIFO streams.
module fir_ch_scheduler
  import fir_sched_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST      = DEF_BURST,
  parameter int unsigned DECIM      = DEF_DECIM,
  localparam int unsigned SEL_W     = width_min1(NUM_CH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_in_dout,
  input  logic [NUM_CH-1:0]            ch_in_empty,
  output logic [NUM_CH-1:0]            ch_in_rd_en,
  output logic [DATA_WIDTH-1:0]        ch_out_din,
  output logic [NUM_CH-1:0]            ch_out_wr_en,
  input  logic [NUM_CH-1:0]            ch_out_full,
  output logic [DATA_WIDTH-1:0]        fir_in_dout,
  output logic                         fir_in_empty,
  input  logic                         fir_in_rd_en,
  input  logic [DATA_WIDTH-1:0]        fir_out_din,
  input  logic                         fir_out_wr_en,
  output logic                         fir_out_full,
  output logic [SEL_W-1:0]             fir_ch_sel,
  output logic                         busy,
  output logic                         err
);

  localparam int unsigned OUT_N = BURST / DECIM;
  localparam int unsigned IN_W  = width_min1(BURST + 1);
  localparam int unsigned OUT_W = width_min1(OUT_N + 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]  grant_q, grant_d;
  logic [IN_W-1:0]   in_cnt_q, in_cnt_d;
  logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic                  pick_hit;
  logic [SEL_W-1:0]      pick_idx;
  logic [DATA_WIDTH-1:0] sel_dout;
  logic                  sel_empty;
  logic                  sel_full;

  rr_pick #(.N(NUM_CH)) u_rr_pick (
    .req_i   (~ch_in_empty),
    .start_i (rr_ptr_q),
    .hit_o   (pick_hit),
    .idx_o   (pick_idx)
  );

  // Per-channel views of the currently granted channel
  always_comb begin
    sel_dout  = '0;
    sel_empty = 1'b1;
    sel_full  = 1'b1;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (grant_q == SEL_W'(k)) begin
        sel_dout  = ch_in_dout[k*DATA_WIDTH +: DATA_WIDTH];
        sel_empty = ch_in_empty[k];
        sel_full  = ch_out_full[k];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    err_d        = err_q;
    ch_in_rd_en  = '0;
    ch_out_wr_en = '0;
    fir_in_empty = 1'b1;
    fir_out_full = 1'b1;
    fir_in_dout  = '0;
    ch_out_din   = fir_out_din;

    case (state_q)
      ST_IDLE: begin
        if (fir_out_wr_en) err_d = 1'b1;
        if (pick_hit) begin
          grant_d   = pick_idx;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = ST_FEED;
        end
      end

      ST_FEED, ST_DRAIN: begin
        fir_out_full = sel_full;
        // A write past the burst's output quota is a protocol error and is dropped
        if (fir_out_wr_en) begin
          if (out_cnt_q == OUT_W'(OUT_N)) begin
            err_d = 1'b1;
          end else if (!sel_full) begin
            ch_out_wr_en[grant_q] = 1'b1;
            out_cnt_d             = out_cnt_q + OUT_W'(1);
          end
        end
        if (state_q == ST_FEED) begin
          fir_in_dout  = sel_dout;
          fir_in_empty = sel_empty | (in_cnt_q == IN_W'(BURST));
          if (fir_in_rd_en && !fir_in_empty) begin
            ch_in_rd_en[grant_q] = 1'b1;
            in_cnt_d             = in_cnt_q + IN_W'(1);
          end
          if (in_cnt_d == IN_W'(BURST)) state_d = ST_DRAIN;
        end
        if (in_cnt_d == IN_W'(BURST) && out_cnt_d == OUT_W'(OUT_N)) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_q == SEL_W'(NUM_CH - 1)) ? '0 : grant_q + SEL_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign fir_ch_sel = grant_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fir_ch_scheduler.sv
// Randomized bench for fir_ch_scheduler: FIFO and engine models plus a burst-level scheduler model.
module tb_fir_ch_scheduler;

  localparam int unsigned N     = 2;
  localparam int unsigned DW    = 32;
  localparam int unsigned BURST = 16;
  localparam int unsigned DECIM = 8;
  localparam int unsigned OPB   = BURST / DECIM;

  logic          clock = 1'b0;
  logic          reset;
  logic [N*DW-1:0] ch_in_dout;
  logic [N-1:0]  ch_in_empty, ch_in_rd_en, ch_out_wr_en, ch_out_full;
  logic [DW-1:0] ch_out_din, fir_in_dout, fir_out_din;
  logic          fir_in_empty, fir_in_rd_en, fir_out_wr_en, fir_out_full;
  logic [0:0]    fir_ch_sel;
  logic          busy, err;

  always #5 clock = ~clock;

  fir_ch_scheduler #(.NUM_CH(N), .DATA_WIDTH(DW), .BURST(BURST), .DECIM(DECIM)) dut (
    .clock(clock), .reset(reset),
    .ch_in_dout(ch_in_dout), .ch_in_empty(ch_in_empty), .ch_in_rd_en(ch_in_rd_en),
    .ch_out_din(ch_out_din), .ch_out_wr_en(ch_out_wr_en), .ch_out_full(ch_out_full),
    .fir_in_dout(fir_in_dout), .fir_in_empty(fir_in_empty), .fir_in_rd_en(fir_in_rd_en),
    .fir_out_din(fir_out_din), .fir_out_wr_en(fir_out_wr_en), .fir_out_full(fir_out_full),
    .fir_ch_sel(fir_ch_sel), .busy(busy), .err(err)
  );

  int errors = 0;
  int checks = 0;

  // Bench-side FIFOs and engine
  logic [DW-1:0] q_in   [N][$];
  logic [DW-1:0] q_out  [N][$];
  logic [DW-1:0] popped [N][$];
  logic [DW-1:0] pend   [N][$];
  logic [DW-1:0] acc    [N];
  int            acnt   [N];

  // Burst-level scheduler model
  bit m_busy, m_err;
  int m_g, m_reads, m_writes, m_rr;
  int grant_log[$];

  int       p_rd = 100, p_wr = 100, p_full = 0;
  bit [N-1:0] force_full = '0;
  bit       spur_wr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_engine();
    for (int k = 0; k < N; k++) begin
      pend[k].delete(); popped[k].delete(); q_out[k].delete();
      acc[k] = '0; acnt[k] = 0;
    end
  endtask

  task automatic step(input bit do_rst);
    logic [N-1:0]  rd_v, wr_v, exp_rd, exp_wr;
    logic [DW-1:0] rd_data, wr_data;
    bit            eng_rd, eng_wr, feed_ok, wr_ok, found;
    int            sel, j;
    @(negedge clock);
    reset = do_rst;
    for (int k = 0; k < N; k++) begin
      ch_in_empty[k]          = (q_in[k].size() == 0);
      ch_in_dout[k*DW +: DW]  = (q_in[k].size() != 0) ? q_in[k][0] : '0;
      ch_out_full[k]          = force_full[k] || ($urandom_range(99) < p_full);
    end
    fir_in_rd_en  = ($urandom_range(99) < p_rd);
    sel           = int'(fir_ch_sel);
    fir_out_wr_en = spur_wr || (pend[sel].size() != 0 && $urandom_range(99) < p_wr);
    fir_out_din   = (pend[sel].size() != 0) ? pend[sel][0] : $urandom();
    #1;
    feed_ok = m_busy && (m_reads < BURST) && !ch_in_empty[m_g];
    wr_ok   = m_busy && fir_out_wr_en && (m_writes < OPB) && !ch_out_full[m_g];
    exp_rd = '0; exp_wr = '0;
    if (feed_ok && fir_in_rd_en) exp_rd[m_g] = 1'b1;
    if (wr_ok) exp_wr[m_g] = 1'b1;
    chk("busy", 64'(busy), 64'(m_busy));
    chk("err", 64'(err), 64'(m_err));
    chk("ch_in_rd_en", 64'(ch_in_rd_en), 64'(exp_rd));
    chk("ch_out_wr_en", 64'(ch_out_wr_en), 64'(exp_wr));
    chk("fir_in_empty", 64'(fir_in_empty), 64'(!feed_ok));
    chk("fir_out_full", 64'(fir_out_full), 64'(m_busy ? ch_out_full[m_g] : 1'b1));
    chk("ch_out_din", 64'(ch_out_din), 64'(fir_out_din));
    if (m_busy) chk("fir_ch_sel", 64'(fir_ch_sel), 64'(m_g));
    if (feed_ok) chk("fir_in_dout", 64'(fir_in_dout), 64'(q_in[m_g][0]));
    else if (!m_busy) chk("fir_in_dout_idle", 64'(fir_in_dout), 64'd0);

    rd_v    = ch_in_rd_en;
    wr_v    = ch_out_wr_en;
    rd_data = fir_in_dout;
    wr_data = fir_out_din;
    eng_rd  = fir_in_rd_en && !fir_in_empty;
    eng_wr  = fir_out_wr_en && !fir_out_full && (pend[sel].size() != 0);

    if (do_rst) begin
      m_busy = 0; m_err = 0; m_rr = 0; m_g = 0; m_reads = 0; m_writes = 0;
    end else begin
      if (fir_out_wr_en && (!m_busy || m_writes >= OPB)) m_err = 1;
      if (!m_busy) begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          j = (m_rr + i) % N;
          if (!found && !ch_in_empty[j]) begin found = 1; m_g = j; end
        end
        if (found) begin
          m_busy = 1; m_reads = 0; m_writes = 0;
          grant_log.push_back(m_g);
        end
      end else begin
        if (exp_rd != 0) m_reads++;
        if (exp_wr != 0) m_writes++;
        if (m_reads == BURST && m_writes == OPB) begin
          m_busy = 0;
          m_rr   = (m_g + 1) % N;
        end
      end
    end

    @(posedge clock);
    for (int k = 0; k < N; k++) begin
      if (rd_v[k] && q_in[k].size() != 0) popped[k].push_back(q_in[k].pop_front());
      if (wr_v[k]) q_out[k].push_back(wr_data);
    end
    if (eng_rd) begin
      acc[sel] = acc[sel] + rd_data;
      acnt[sel]++;
      if (acnt[sel] == DECIM) begin
        pend[sel].push_back(acc[sel]);
        acc[sel] = '0; acnt[sel] = 0;
      end
    end
    if (eng_wr) void'(pend[sel].pop_front());
    if (do_rst) clear_engine();
  endtask

  task automatic push_burst(input int ch, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) q_in[ch].push_back(base + DW'(i));
  endtask

  task automatic run_idle(input int budget);
    int  c;
    bit  pending;
    c = 0;
    do begin
      pending = m_busy;
      for (int k = 0; k < N; k++) if (q_in[k].size() != 0) pending = 1;
      if (pending) begin step(0); c++; end
    end while (pending && c < budget);
    if (pending) begin
      checks++; errors++;
      $display("FAIL run_idle_timeout: still busy after %0d cycles", c);
    end
  endtask

  // Every output must equal the DECIM-sample sum of that channel's own inputs
  task automatic check_data();
    logic [DW-1:0] s;
    int n;
    for (int k = 0; k < N; k++) begin
      n = popped[k].size() / DECIM;
      chk($sformatf("out_count_ch%0d", k), 64'(q_out[k].size()), 64'(n));
      for (int o = 0; o < n && o < q_out[k].size(); o++) begin
        s = '0;
        for (int i = 0; i < DECIM; i++) s = s + popped[k][o*DECIM + i];
        chk($sformatf("out_data_ch%0d_%0d", k, o), 64'(q_out[k][o]), 64'(s));
      end
      popped[k].delete(); q_out[k].delete();
    end
  endtask

  initial begin
    int c;
    reset = 1'b1; ch_in_dout = '0; ch_in_empty = '1; ch_out_full = '0;
    fir_in_rd_en = 1'b0; fir_out_wr_en = 1'b0; fir_out_din = '0;
    m_busy = 0; m_err = 0; m_g = 0; m_reads = 0; m_writes = 0; m_rr = 0;
    clear_engine();

    step(1); step(1);
    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_fir_in_empty", 64'(fir_in_empty), 64'd1);
    chk("rst_fir_out_full", 64'(fir_out_full), 64'd1);
    chk("rst_rd_en", 64'(ch_in_rd_en), 64'd0);
    chk("rst_wr_en", 64'(ch_out_wr_en), 64'd0);
    chk("rst_sel", 64'(fir_ch_sel), 64'd0);

    // Single burst on ch0 with samples 1..16: outputs 36 and 100
    push_burst(0, 16, 32'd1);
    run_idle(200);
    chk("t1_grants", 64'(grant_log.size()), 64'd1);
    if (grant_log.size() > 0) chk("t1_grant0", 64'(grant_log[0]), 64'd0);
    chk("t1_reads", 64'(popped[0].size()), 64'd16);
    chk("t1_nout", 64'(q_out[0].size()), 64'd2);
    if (q_out[0].size() == 2) begin
      chk("t1_out0", 64'(q_out[0][0]), 64'd36);
      chk("t1_out1", 64'(q_out[0][1]), 64'd100);
    end
    chk("t1_rr", 64'(m_rr), 64'd1);
    check_data();

    // Two full channels alternate
    step(1); grant_log.delete();
    p_rd = 70; p_wr = 70;
    push_burst(0, 32, 32'h0000_1000);
    push_burst(1, 32, 32'h0001_0000);
    run_idle(1000);
    chk("t2_grants", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk($sformatf("t2_order%0d", i), 64'(grant_log[i]), 64'(i % 2));
    check_data();

    // Starved channel keeps its grant until the burst completes
    step(1); grant_log.delete();
    p_rd = 100; p_wr = 100;
    push_burst(0, 10, 32'h0000_2000);
    push_burst(1, 16, 32'h0002_0000);
    for (int i = 0; i < 20; i++) step(0);
    #3;
    chk("t3_busy_held", 64'(busy), 64'd1);
    chk("t3_sel_held", 64'(fir_ch_sel), 64'd0);
    chk("t3_partial_reads", 64'(popped[0].size()), 64'd10);
    push_burst(0, 6, 32'h0000_200a);
    run_idle(500);
    chk("t3_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      chk("t3_order0", 64'(grant_log[0]), 64'd0);
      chk("t3_order1", 64'(grant_log[1]), 64'd1);
    end
    check_data();

    // Output FIFO full during DRAIN freezes writes
    step(1);
    p_wr = 0;
    push_burst(0, 16, 32'h0000_3000);
    c = 0;
    while (m_reads < BURST && c < 100) begin step(0); c++; end
    chk("t4_reached_drain", 64'(m_reads), 64'(BURST));
    force_full[0] = 1'b1; p_wr = 100;
    for (int i = 0; i < 5; i++) step(0);
    #3;
    chk("t4_no_writes", 64'(q_out[0].size()), 64'd0);
    chk("t4_full", 64'(fir_out_full), 64'd1);
    force_full[0] = 1'b0;
    run_idle(100);
    chk("t4_writes", 64'(q_out[0].size()), 64'd2);
    check_data();

    // Spurious engine write in IDLE sets sticky err
    step(1);
    spur_wr = 1'b1; step(0); spur_wr = 1'b0;
    step(0);
    #3;
    chk("t5_err_set", 64'(err), 64'd1);
    for (int i = 0; i < 3; i++) step(0);
    #3;
    chk("t5_err_sticky", 64'(err), 64'd1);
    step(1);
    #3;
    chk("t5_err_cleared", 64'(err), 64'd0);

    // Reset mid-FEED
    push_burst(1, 16, 32'h0003_0000);
    c = 0;
    while (!(m_busy && m_reads == 7) && c < 100) begin step(0); c++; end
    chk("t6_in_cnt7", 64'(m_reads), 64'd7);
    step(1);
    #3;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_fir_in_empty", 64'(fir_in_empty), 64'd1);
    chk("t6_sel", 64'(fir_ch_sel), 64'd0);
    for (int k = 0; k < N; k++) q_in[k].delete();
    for (int i = 0; i < 3; i++) step(0);

    // Randomized traffic with back-pressure
    step(1); grant_log.delete();
    p_rd = 60; p_wr = 60; p_full = 25;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++)
        push_burst(k, int'($urandom_range(2)) * 16, $urandom());
      run_idle(3000);
      check_data();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
